debug_read_arbiter: RTL

//  Shares the CPU's single debug read port (address out, 32-bit data in) between two requesters:

---
 rtl/debug_read_arbiter_pkg.sv | 22 ++
 rtl/debug_read_arbiter_rr_arb2.sv | 20 ++
 rtl/debug_read_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/debug_read_arbiter_pkg.sv
// Shared definitions for the debug read arbiter: FSM encodings, port
// indices, default debug bus widths and the read-latency range check.
package debug_read_arbiter_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_WAIT = 1'b1;

   localparam int PORT_LCD  = 0;
   localparam int PORT_HOST = 1;

   localparam int DBG_ADDR_W = 7;
   localparam int DBG_DATA_W = 32;

   localparam int CNT_W   = 4;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 15;

   function automatic bit lat_ok(input int lat);
      return (lat >= LAT_MIN) && (lat <= LAT_MAX);
   endfunction

endpackage

// File: rtl/debug_read_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way picker.
// Ports: req[1:0] requests, last = port granted previously,
//        fixed = port 0 always wins a tie, gnt[1:0] one-hot grant
//        (all zero when nothing is requested).
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       fixed,
   output logic [1:0] gnt
);

   // Port 0 wins a tie under fixed priority, or when port 1 went last.
   logic w_p0_wins;

   assign w_p0_wins = fixed | last;

   assign gnt[0] = req[0] & (~req[1] | w_p0_wins);
   assign gnt[1] = req[1] & (~req[0] | ~w_p0_wins);

endmodule

// File: rtl/debug_read_arbiter.sv
// debug_read_arbiter: shares the CPU debug read port between the LCD
// refresher (port 0) and the host register dumper (port 1).
// Ports: clk, rst (async, active-high);
//        reqN/addrN in, ackN/validN/dataN out for N = 0, 1;
//        dbg_addr out / dbg_data in to the CPU debug port;
//        busy high while a read is outstanding.
module debug_read_arbiter
   import debug_read_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DBG_ADDR_W,
   parameter int DATA_W     = DBG_DATA_W,
   parameter int RD_LAT     = 1,
   parameter int PRIO_FIXED = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              ack0,
   output logic              valid0,
   output logic [DATA_W-1:0] data0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              ack1,
   output logic              valid1,
   output logic [DATA_W-1:0] data1,
   output logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              busy
);

   if (!lat_ok(RD_LAT)) begin : g_bad_lat
      $error("debug_read_arbiter: RD_LAT must be within 1..15");
   end

   // Counter value on the edge that samples dbg_data.
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT - 1);

   logic              r_state;
   logic              r_last;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ack0;
   logic              r_ack1;
   logic              r_valid0;
   logic              r_valid1;
   logic [DATA_W-1:0] r_data0;
   logic [DATA_W-1:0] r_data1;
   logic [ADDR_W-1:0] r_dbg_addr;

   logic [1:0]        w_gnt;
   logic              w_fixed;

   assign w_fixed = (PRIO_FIXED != 0);

   rr_arb2 u_arb (
      .req   ({req1, req0}),
      .last  (r_last),
      .fixed (w_fixed),
      .gnt   (w_gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_last     <= 1'b1;
         r_cnt      <= '0;
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_valid0   <= 1'b0;
         r_valid1   <= 1'b0;
         r_data0    <= '0;
         r_data1    <= '0;
         r_dbg_addr <= '0;
      end else begin
         // ack and valid are single-cycle pulses.
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_valid0 <= 1'b0;
         r_valid1 <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (|w_gnt) begin
                  r_state    <= ST_WAIT;
                  r_cnt      <= '0;
                  r_last     <= w_gnt[PORT_HOST];
                  r_ack0     <= w_gnt[PORT_LCD];
                  r_ack1     <= w_gnt[PORT_HOST];
                  r_dbg_addr <= w_gnt[PORT_HOST] ? addr1 : addr0;
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               // r_last holds the port that owns this read.
               if (r_cnt == LAT_LAST) begin
                  r_state <= ST_IDLE;
                  if (r_last) begin
                     r_data1  <= dbg_data;
                     r_valid1 <= 1'b1;
                  end else begin
                     r_data0  <= dbg_data;
                     r_valid0 <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ack0     = r_ack0;
   assign ack1     = r_ack1;
   assign valid0   = r_valid0;
   assign valid1   = r_valid1;
   assign data0    = r_data0;
   assign data1    = r_data1;
   assign dbg_addr = r_dbg_addr;
   assign busy     = (r_state == ST_WAIT);

endmodule
